// File: rtl/pkt_drop_buffer_if.sv
// -----------------------------------------------------------------------------
// pkt_drop_buffer_if
// AXI4-Stream style bundle used on both sides of the packet drop buffer.
//   tdata  : beat payload
//   tstrb  : byte enables, one bit per payload byte
//   tuser  : per-beat metadata
//   tvalid : beat present (driven by master)
//   tready : sink can take the beat (driven by slave)
//   tlast  : final beat of a packet
// Modports:
//   master : drives the beat, samples tready
//   slave  : samples the beat, drives tready
// -----------------------------------------------------------------------------
interface pkt_drop_buffer_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (
    output tdata,
    output tstrb,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tstrb,
    input  tuser,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/pkt_drop_buffer.sv
// -----------------------------------------------------------------------------
// pkt_drop_buffer
// Store-and-forward packet buffer sitting right after the packet cutter.
// It never backpressures the cutter, forwards only complete packets and
// tail-drops any packet that does not fit. Drop and forward counters feed the
// stats registers.
//
// Ports:
//   axi_aclk   : single clock
//   axi_reset  : synchronous reset, active-high
//   s_axis     : input stream from the cutter (slave modport); tready is
//                0 in reset and 1 from the cycle after reset is released
//   m_axis     : output stream of whole packets (master modport)
//   drop_count : number of packets dropped, wraps
//   fwd_count  : number of packets whose tlast beat was handshaken on m_axis,
//                wraps
//
// Each buffer entry is {tlast, tuser, tstrb, tdata}. Pointers carry one extra
// wrap bit so that full and empty can be told apart. Only words below
// commit_ptr are ever read, so a packet being written (or rewound after
// running out of space) is invisible to the read side.
// -----------------------------------------------------------------------------
module pkt_drop_buffer #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int DEPTH_WORDS          = 512,
  parameter int MAX_PKT_WORDS        = 48
) (
  input  logic                axi_aclk,
  input  logic                axi_reset,
  pkt_drop_buffer_if.slave    s_axis,
  pkt_drop_buffer_if.master   m_axis,
  output logic [31:0]         drop_count,
  output logic [31:0]         fwd_count
);

  localparam int DW  = C_S_AXIS_DATA_WIDTH;
  localparam int SW  = DW / 8;
  localparam int UW  = C_S_AXIS_TUSER_WIDTH;
  localparam int EW  = 1 + UW + SW + DW;
  localparam int ODW = C_M_AXIS_DATA_WIDTH;
  localparam int OSW = ODW / 8;
  localparam int OUW = C_M_AXIS_TUSER_WIDTH;
  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int PW  = AW + 1;

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW:0]   DEPTH_W   = (PW+1)'(DEPTH_WORDS);
  localparam logic [PW:0]   RESERVE_W = (PW+1)'(MAX_PKT_WORDS);

  typedef enum logic [1:0] {
    ST_SOP,
    ST_WRITE,
    ST_DROP
  } wr_state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wr_state_t         state_reg, state_next;
  logic              ready_reg;
  logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]     commit_ptr_reg, commit_ptr_next;
  logic [PW-1:0]     pkt_start_reg, pkt_start_next;
  logic [PW-1:0]     rd_ptr_reg;
  logic [31:0]       drop_count_reg, fwd_count_reg;

  logic [EW-1:0]     mem [DEPTH_WORDS];
  logic              rd_valid_reg;
  logic [EW-1:0]     rd_data_reg;

  logic [1:0]        skid_cnt_reg, skid_cnt_next;
  logic [EW-1:0]     skid_slot_reg [2];

  // ---------------------------------------------------------------------------
  // Write-side combinational signals
  // ---------------------------------------------------------------------------
  logic              beat_valid;
  logic              wr_en;
  logic              drop_inc;
  logic [EW-1:0]     wr_entry;
  logic [PW-1:0]     used_words;
  logic [PW:0]       free_words;
  logic              has_reserve;
  logic              is_full;

  // ---------------------------------------------------------------------------
  // Read-side combinational signals
  // ---------------------------------------------------------------------------
  logic              ram_empty;
  logic              pop;
  logic              fwd_inc;
  logic              rd_en;
  logic [1:0]        in_flight;
  logic [1:0]        slot_load;
  logic              slot0_from_ram;

  assign s_axis.tready = ready_reg & ~axi_reset;
  assign beat_valid    = s_axis.tvalid & ready_reg;
  assign wr_entry      = {s_axis.tlast, s_axis.tuser, s_axis.tstrb, s_axis.tdata};

  // Space is judged against the read pointer as it stood before this cycle,
  // so a read issued in the same cycle never makes room early.
  assign used_words  = wr_ptr_reg - rd_ptr_reg;
  assign free_words  = DEPTH_W - {1'b0, used_words};
  assign has_reserve = (free_words >= RESERVE_W);
  assign is_full     = (free_words == '0);

  // ---------------------------------------------------------------------------
  // Write FSM: next state and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    commit_ptr_next = commit_ptr_reg;
    pkt_start_next  = pkt_start_reg;
    wr_en           = 1'b0;
    drop_inc        = 1'b0;

    if (beat_valid) begin
      case (state_reg)
        ST_SOP: begin
          // A new packet is only admitted when a worst-case packet fits.
          if (has_reserve) begin
            wr_en          = 1'b1;
            wr_ptr_next    = wr_ptr_reg + PTR_ONE;
            pkt_start_next = wr_ptr_reg;
            if (s_axis.tlast) begin
              commit_ptr_next = wr_ptr_reg + PTR_ONE;
            end else begin
              state_next = ST_WRITE;
            end
          end else begin
            if (s_axis.tlast) begin
              drop_inc = 1'b1;
            end else begin
              state_next = ST_DROP;
            end
          end
        end

        ST_WRITE: begin
          if (!is_full) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
            if (s_axis.tlast) begin
              commit_ptr_next = wr_ptr_reg + PTR_ONE;
              state_next      = ST_SOP;
            end
          end else begin
            // Overlong packet: throw away what was written so far by
            // rewinding to its first word; the rest of it is discarded.
            wr_ptr_next = pkt_start_reg;
            if (s_axis.tlast) begin
              drop_inc   = 1'b1;
              state_next = ST_SOP;
            end else begin
              state_next = ST_DROP;
            end
          end
        end

        ST_DROP: begin
          if (s_axis.tlast) begin
            drop_inc   = 1'b1;
            state_next = ST_SOP;
          end
        end

        default: begin
          state_next = ST_SOP;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: RAM read stage feeding a 2-entry output skid register.
  // A read is issued only when the words already in the skid plus the one in
  // flight from the RAM, less the one leaving this cycle, leave a free slot.
  // ---------------------------------------------------------------------------
  assign ram_empty = (commit_ptr_reg == rd_ptr_reg);
  assign pop       = (skid_cnt_reg != 2'd0) & m_axis.tready;
  assign fwd_inc   = pop & skid_slot_reg[0][EW-1];
  assign in_flight = skid_cnt_reg + {1'b0, rd_valid_reg};
  assign rd_en     = ~ram_empty & ((in_flight - {1'b0, pop}) < 2'd2);

  always_comb begin
    skid_cnt_next  = skid_cnt_reg + {1'b0, rd_valid_reg} - {1'b0, pop};
    slot_load      = 2'b00;
    slot0_from_ram = 1'b0;

    if (pop) begin
      if (skid_cnt_reg == 2'd2) begin
        // Head leaves, second entry moves up, new word (if any) fills behind.
        slot_load[0] = 1'b1;
        if (rd_valid_reg) begin
          slot_load[1] = 1'b1;
        end
      end else if (rd_valid_reg) begin
        slot_load[0]   = 1'b1;
        slot0_from_ram = 1'b1;
      end
    end else if (rd_valid_reg) begin
      if (skid_cnt_reg == 2'd0) begin
        slot_load[0]   = 1'b1;
        slot0_from_ram = 1'b1;
      end else begin
        slot_load[1] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_reg      <= ST_SOP;
      ready_reg      <= 1'b0;
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      pkt_start_reg  <= '0;
      rd_ptr_reg     <= '0;
      rd_valid_reg   <= 1'b0;
      skid_cnt_reg   <= 2'd0;
      drop_count_reg <= 32'd0;
      fwd_count_reg  <= 32'd0;
    end else begin
      state_reg      <= state_next;
      ready_reg      <= 1'b1;
      wr_ptr_reg     <= wr_ptr_next;
      commit_ptr_reg <= commit_ptr_next;
      pkt_start_reg  <= pkt_start_next;
      rd_valid_reg   <= rd_en;
      skid_cnt_reg   <= skid_cnt_next;
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (drop_inc) begin
        drop_count_reg <= drop_count_reg + 32'd1;
      end
      if (fwd_inc) begin
        fwd_count_reg <= fwd_count_reg + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Packet RAM with registered read
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_aclk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_entry;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // Skid data slots; validity is tracked by skid_cnt_reg, so no reset needed
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_aclk) begin
    if (slot_load[0]) begin
      skid_slot_reg[0] <= slot0_from_ram ? rd_data_reg : skid_slot_reg[1];
    end
    if (slot_load[1]) begin
      skid_slot_reg[1] <= rd_data_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m_axis.tvalid = (skid_cnt_reg != 2'd0);
  assign m_axis.tdata  = skid_slot_reg[0][ODW-1:0];
  assign m_axis.tstrb  = skid_slot_reg[0][ODW+OSW-1:ODW];
  assign m_axis.tuser  = skid_slot_reg[0][ODW+OSW+OUW-1:ODW+OSW];
  assign m_axis.tlast  = skid_slot_reg[0][EW-1];

  assign drop_count = drop_count_reg;
  assign fwd_count  = fwd_count_reg;

endmodule
